// File: rtl/fetch_align_queue.sv
// Fetch alignment queue: extracts the 16-byte instruction window at fip from an
// even/odd ICache line pair and buffers it in a DEPTH-entry FIFO toward decode.
module fetch_align_queue #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       line_valid,
  input  logic [LINE_W-1:0]          even_line,
  input  logic [LINE_W-1:0]          odd_line,
  input  logic [ADDR_W-1:0]          fip,
  input  logic                       cache_miss_even,
  input  logic                       cache_miss_odd,
  output logic                       in_ready,
  output logic                       miss_stall,
  output logic                       pkt_valid,
  output logic [LINE_W-1:0]          pkt_bytes,
  output logic [ADDR_W-1:0]          pkt_eip,
  input  logic                       pkt_ready,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [LINE_W-1:0]   bytes_q [DEPTH];
  logic [LINE_W-1:0]   bytes_d [DEPTH];
  logic [ADDR_W-1:0]   eip_q   [DEPTH];
  logic [ADDR_W-1:0]   eip_d   [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                miss_stall_q, miss_stall_d;

  logic [LINE_W-1:0]   lo, hi, packet;
  logic [2*LINE_W-1:0] window, shifted;
  logic                push_ok, pop_ok, any_miss;

  // fip[4] picks which bank holds the first wanted byte; fip[3:0] is the byte offset
  always_comb begin
    lo      = fip[4] ? odd_line  : even_line;
    hi      = fip[4] ? even_line : odd_line;
    window  = {hi, lo};
    shifted = window >> {fip[3:0], 3'b000};
    packet  = shifted[LINE_W-1:0];
  end

  always_comb begin
    in_ready   = (count_q < FULL);
    pkt_valid  = (count_q != '0);
    any_miss   = cache_miss_even | cache_miss_odd;
    push_ok    = line_valid & in_ready & ~any_miss & ~flush;
    pop_ok     = pkt_valid & pkt_ready & ~flush;
    pkt_bytes  = bytes_q[rd_ptr_q];
    pkt_eip    = eip_q[rd_ptr_q];
    miss_stall = miss_stall_q;
    count      = count_q;
  end

  always_comb begin
    bytes_d      = bytes_q;
    eip_d        = eip_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    miss_stall_d = line_valid & in_ready & ~flush & any_miss;
    if (push_ok) begin
      bytes_d[wr_ptr_q] = packet;
      eip_d[wr_ptr_q]   = fip;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Resteer discards every queued packet and any same-cycle push or pop
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      miss_stall_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      miss_stall_q <= miss_stall_d;
    end
  end

  // Packet storage carries no reset; occupancy alone qualifies it
  always_ff @(posedge clk) begin
    bytes_q <= bytes_d;
    eip_q   <= eip_d;
  end

endmodule

// File: tb/tb_fetch_align_queue.sv
// Scoreboard bench for fetch_align_queue: stimulus queues expected packets,
// a monitor compares them as decode pops the head.
module tb_fetch_align_queue;
  logic         clk = 1'b0;
  logic         rst, flush, line_valid, cache_miss_even, cache_miss_odd, pkt_ready;
  logic [127:0] even_line, odd_line, pkt_bytes;
  logic [31:0]  fip, pkt_eip;
  logic         in_ready, miss_stall, pkt_valid;
  logic [2:0]   count;

  typedef struct packed {
    logic [127:0] b;
    logic [31:0]  e;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] L0 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] L1 = 128'h1F1E1D1C1B1A19181716151413121110;
  localparam logic [127:0] L2 = 128'h2F2E2D2C2B2A29282726252423222120;

  fetch_align_queue #(.DEPTH(4), .LINE_W(128), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .line_valid(line_valid),
    .even_line(even_line), .odd_line(odd_line), .fip(fip),
    .cache_miss_even(cache_miss_even), .cache_miss_odd(cache_miss_odd),
    .in_ready(in_ready), .miss_stall(miss_stall), .pkt_valid(pkt_valid),
    .pkt_bytes(pkt_bytes), .pkt_eip(pkt_eip), .pkt_ready(pkt_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    line_valid      = 1'b0;
    flush           = 1'b0;
    cache_miss_even = 1'b0;
    cache_miss_odd  = 1'b0;
    pkt_ready       = 1'b0;
  endtask

  // Present a line pair; queue the expected packet when it should be accepted
  task automatic present(input logic [31:0] f, input logic [127:0] ev, input logic [127:0] od,
                         input bit accept, input logic [127:0] expb);
    line_valid = 1'b1;
    fip        = f;
    even_line  = ev;
    odd_line   = od;
    if (accept) exp_q.push_back('{b: expb, e: f});
  endtask

  task automatic drain(input int n);
    line_valid = 1'b0;
    pkt_ready  = 1'b1;
    repeat (n) step();
    pkt_ready  = 1'b0;
  endtask

  // Monitor: every real pop is compared against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !flush && pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop_eip", {96'd0, pkt_eip}, 128'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("pop_eip", {96'd0, pkt_eip}, {96'd0, e.e});
          chk("pop_bytes", pkt_bytes, e.b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    fip = '0; even_line = '0; odd_line = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_pkt_valid", {127'd0, pkt_valid}, 128'd0);
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    chk("reset_count", {125'd0, count}, 128'd0);
    chk("reset_miss_stall", {127'd0, miss_stall}, 128'd0);

    // Aligned push
    present(32'h1000, L0, L1, 1'b1, L0);
    step();
    idle();
    chk("aligned_pkt_valid", {127'd0, pkt_valid}, 128'd1);
    chk("aligned_count", {125'd0, count}, 128'd1);
    chk("aligned_eip_head", {96'd0, pkt_eip}, 128'h1000);
    drain(1);

    // Unaligned, odd bank first: bytes 0x13..0x1F then 0x20..0x22
    present(32'h1013, L2, L1, 1'b1, 128'h2221201F1E1D1C1B1A19181716151413);
    step();
    // Offset 15 with even bank first: byte 0x0F then 0x10..0x1E
    present(32'h200F, L0, L1, 1'b1, 128'h1E1D1C1B1A191817161514131211100F);
    step();
    idle();
    drain(2);

    // Fill and backpressure
    for (int i = 0; i < 4; i++) begin
      present(32'(i * 16), L0, L1, 1'b1, i[0] ? L1 : L0);
      step();
    end
    present(32'h40, L0, L1, 1'b0, '0);
    chk("full_in_ready", {127'd0, in_ready}, 128'd0);
    chk("full_count", {125'd0, count}, 128'd4);
    step();
    idle();
    chk("full_count_after_5th", {125'd0, count}, 128'd4);
    drain(4);
    chk("drained_count", {125'd0, count}, 128'd0);

    // Simultaneous push and pop at count=2 across pointer wrap
    present(32'h100, L0, L1, 1'b1, L0);
    step();
    present(32'h110, L0, L1, 1'b1, L1);
    step();
    chk("pp_start_count", {125'd0, count}, 128'd2);
    pkt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      present(32'h120 + 32'(i * 16), L0, L1, 1'b1, i[0] ? L1 : L0);
      step();
      chk("pp_count", {125'd0, count}, 128'd2);
    end
    idle();
    drain(2);

    // Miss handling
    present(32'h2000, L0, L1, 1'b0, '0);
    cache_miss_odd = 1'b1;
    step();
    cache_miss_odd = 1'b0;
    line_valid = 1'b0;
    chk("miss_count", {125'd0, count}, 128'd0);
    chk("miss_stall_set", {127'd0, miss_stall}, 128'd1);
    present(32'h2000, L0, L1, 1'b1, L0);
    step();
    idle();
    chk("miss_retry_count", {125'd0, count}, 128'd1);
    chk("miss_stall_clear", {127'd0, miss_stall}, 128'd0);
    drain(1);

    // Flush with a same-cycle push and pkt_ready
    for (int i = 0; i < 3; i++) begin
      present(32'h3000 + 32'(i * 16), L0, L1, 1'b1, i[0] ? L1 : L0);
      step();
    end
    chk("preflush_count", {125'd0, count}, 128'd3);
    present(32'h3030, L0, L1, 1'b0, '0);
    pkt_ready = 1'b1;
    flush = 1'b1;
    step();
    exp_q.delete();
    idle();
    chk("flush_count", {125'd0, count}, 128'd0);
    chk("flush_pkt_valid", {127'd0, pkt_valid}, 128'd0);
    chk("flush_in_ready", {127'd0, in_ready}, 128'd1);

    // Reset while holding two entries
    present(32'h4000, L0, L1, 1'b1, L0);
    step();
    present(32'h4010, L0, L1, 1'b1, L1);
    step();
    idle();
    chk("prerst_count", {125'd0, count}, 128'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("rst_count", {125'd0, count}, 128'd0);
    chk("rst_pkt_valid", {127'd0, pkt_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // Queue usable again after reset
    present(32'h5010, L0, L2, 1'b1, L2);
    step();
    idle();
    drain(1);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_align_queue.md
Name: fetch_align_queue

Overview:
- Consumer end of the fetch_1 ICache line interface; sits between fetch_1 and decode.
- Each cycle it takes one even/odd 128-bit line pair plus the fetch address, and extracts the 16-byte instruction window that starts at that address.
- Pushes the window into a DEPTH-entry FIFO and presents entries to decode with a valid/ready handshake.
- Flushes all entries on resteer.

Parameters:
- DEPTH, 4, number of queued 16-byte packets; power of 2, minimum 2.
- LINE_W, 128, bits per ICache line; fixed at 128.
- ADDR_W, 32, fetch address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  resteer; empties the queue.
- line_valid  in  1  fetch_1 is presenting a line pair this cycle.
- even_line  in  128  line from the even bank.
- odd_line  in  128  line from the odd bank.
- fip  in  ADDR_W  byte address of the first wanted byte.
- cache_miss_even  in  1  even bank missed this cycle.
- cache_miss_odd  in  1  odd bank missed this cycle.
- in_ready  out  1  queue can accept a push.
- miss_stall  out  1  registered; last presented pair was dropped because of a miss.
- pkt_valid  out  1  head entry is valid.
- pkt_bytes  out  128  head packet; byte 0 is in bits [7:0].
- pkt_eip  out  ADDR_W  fip captured with the head packet.
- pkt_ready  in  1  decode consumes the head this cycle.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst=1 at posedge):
  - rd_ptr=0, wr_ptr=0, count=0, miss_stall=0.
  - pkt_valid=0, in_ready=1.
  - pkt_bytes and pkt_eip are don't-care while pkt_valid=0.
- Window formation (combinational):
  - fip[4]=0: lo=even_line, hi=odd_line.
  - fip[4]=1: lo=odd_line, hi=even_line.
  - window={hi,lo}, 256 bits.
  - packet = bits [8*fip[3:0] +: 128] of window, so offset 0 gives lo unchanged and offset 15 gives lo byte 15 followed by hi bytes 0..14.
- Flow control:
  - push_ok = line_valid & in_ready & ~cache_miss_even & ~cache_miss_odd & ~flush.
  - pop_ok = pkt_valid & pkt_ready & ~flush.
  - in_ready = (count < DEPTH). It does not depend on pkt_ready, so there is no full-queue pass-through.
  - pkt_valid = (count != 0).
  - Push writes {packet, fip} at wr_ptr, then increments wr_ptr modulo DEPTH.
  - Pop increments rd_ptr modulo DEPTH.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: unchanged. Legal at any count 1..DEPTH-1; at count=DEPTH no push is possible because in_ready=0.
- Head outputs: pkt_bytes and pkt_eip are the entry at rd_ptr, read combinationally. Data is stable while pkt_valid=1 and pkt_ready=0.
- Latency: a packet pushed in cycle N is visible at the head in cycle N+1 when the queue was empty.
- miss_stall:
  - Next value = line_valid & in_ready & ~flush & (cache_miss_even | cache_miss_odd).
  - No entry is written on a miss; fetch_1 re-presents the same fip.
- Flush (takes priority over push and pop):
  - Next cycle: rd_ptr=wr_ptr=0, count=0, miss_stall=0.
  - A same-cycle push is dropped; a same-cycle pkt_ready is ignored.
- rst behaves identically to flush and also overrides it. A reset in the middle of a burst discards all entries.
- Inputs are ignored while line_valid=0; no state changes except pops.
- The queue never overflows or underflows. A push attempted while full is blocked by in_ready=0; a pkt_ready with count=0 has no effect.

Test Plan:
- Aligned push:
  - Stimulus: after reset, fip=0x1000, even_line=128'h0F0E..00, odd_line=128'h1F1E..10, line_valid=1 for 1 cycle.
  - Required: next cycle pkt_valid=1, pkt_bytes=128'h0F0E..00, pkt_eip=0x1000, count=1.
- Unaligned, odd-first window:
  - Stimulus: fip=0x1013, odd_line bytes 0x10..0x1F, even_line bytes 0x20..0x2F.
  - Required: pkt_bytes byte 0=0x13, byte 12=0x1F, byte 13=0x20, byte 15=0x22.
- Fill and backpressure:
  - Stimulus: DEPTH=4, 5 back-to-back pushes with fip=0x0,0x10,0x20,0x30,0x40, pkt_ready=0.
  - Required: count reaches 4 and in_ready=0; the 5th pair is not accepted; pops return eip 0x0, 0x10, 0x20, 0x30 in order.
- Simultaneous push and pop at count=2, plus pointer wrap:
  - Stimulus: 10 cycles with push and pop every cycle.
  - Required: count stays 2; pkt_eip sequence is preserved across the pointer wrap.
- Miss handling:
  - Stimulus: line_valid=1, cache_miss_odd=1, fip=0x2000.
  - Required: no push, count unchanged, miss_stall=1 next cycle; re-presenting without a miss pushes eip 0x2000 and miss_stall returns to 0.
- Flush and reset priority:
  - Stimulus: count=3, then flush=1 together with a valid push and pkt_ready=1.
  - Required: next cycle count=0, pkt_valid=0, in_ready=1, push dropped.
  - Stimulus: rst=1 while count=2.
  - Required: same empty state on the next cycle.
